// File: rtl/div_pkg.sv
// Shared definitions for the divide / HI-LO sequencing stage.
//   state_t    : FSM states of div_hilo_ctrl (IDLE -> RUN -> FIX -> IDLE)
//   DIV_CYCLES : default operand width, which is also the restoring-divide step count
package div_pkg;

    localparam int unsigned DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO registers.
//   clk, reset          : clock, synchronous active-high reset (clears HI and LO)
//   commit              : divide-result write (takes priority over MTHI/MTLO)
//   commit_hi/commit_lo : remainder / quotient written on commit
//   mt_hi/mt_lo         : MTHI / MTLO write enables (already qualified by the caller)
//   mt_data             : MTHI / MTLO write data
//   hi/lo               : register contents
module hilo_regs #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit,
    input  logic [DATA_W-1:0] commit_hi,
    input  logic [DATA_W-1:0] commit_lo,
    input  logic              mt_hi,
    input  logic              mt_lo,
    input  logic [DATA_W-1:0] mt_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= commit_hi;
            lo <= commit_lo;
        end else begin
            if (mt_hi) hi <= mt_data;
            if (mt_lo) lo <= mt_data;
        end
    end

endmodule

// File: rtl/div_hilo_ctrl.sv
// Divide sequencing stage: accepts DIV/DIVU, runs a DATA_W-step restoring divide on
// operand magnitudes, applies MIPS sign rules and commits into HI/LO.
//   clk, reset         : clock, synchronous active-high reset
//   div_start          : request pulse (sampled only when idle)
//   div_unsigned       : 1 = DIVU, 0 = DIV
//   rs_val / rt_val    : dividend / divisor
//   mt_hi/mt_lo/mt_data: MTHI / MTLO writes (accepted only when idle)
//   busy               : divide in progress
//   done               : one-cycle pulse at divide completion or zero-divisor abort
//   div_zero           : one-cycle pulse when the divisor was zero
//   hi / lo            : remainder / quotient registers
module div_hilo_ctrl
    import div_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              div_start,
    input  logic              div_unsigned,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              mt_hi,
    input  logic              mt_lo,
    input  logic [DATA_W-1:0] mt_data,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned          CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvs;
    logic              q_neg;
    logic              r_neg;

    logic [DATA_W-1:0] rs_mag;
    logic [DATA_W-1:0] rt_mag;
    logic [DATA_W:0]   sh;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;
    logic              commit;
    logic              mt_hi_en;
    logic              mt_lo_en;

    always_comb begin
        rs_mag = (!div_unsigned && rs_val[DATA_W-1]) ? -rs_val : rs_val;
        rt_mag = (!div_unsigned && rt_val[DATA_W-1]) ? -rt_val : rt_val;
        // One restoring step: shift next dividend bit into the partial remainder and
        // try to subtract; the extra top bit of diff is the borrow.
        sh     = {rem, quo[DATA_W-1]};
        diff   = sh - {1'b0, dvs};
        res_lo = q_neg ? -quo : quo;
        res_hi = r_neg ? -rem : rem;
        commit   = (state == ST_FIX);
        mt_hi_en = mt_hi && (state == ST_IDLE);
        mt_lo_en = mt_lo && (state == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (div_start) begin
                        if (rt_val == '0) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            quo   <= rs_mag;
                            dvs   <= rt_mag;
                            rem   <= '0;
                            cnt   <= '0;
                            q_neg <= !div_unsigned && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
                            r_neg <= !div_unsigned && rs_val[DATA_W-1];
                            busy  <= 1'b1;
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // When the subtraction borrows, sh < dvs so it fits in DATA_W bits.
                    if (!diff[DATA_W]) begin
                        rem <= diff[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        rem <= sh[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= ST_FIX;
                end
                ST_FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    hilo_regs #(.DATA_W(DATA_W)) u_hilo (
        .clk       (clk),
        .reset     (reset),
        .commit    (commit),
        .commit_hi (res_hi),
        .commit_lo (res_lo),
        .mt_hi     (mt_hi_en),
        .mt_lo     (mt_lo_en),
        .mt_data   (mt_data),
        .hi        (hi),
        .lo        (lo)
    );

endmodule

// File: tb/tb_div_hilo_ctrl.sv
module tb_div_hilo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_start;
    logic        div_unsigned;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    div_hilo_ctrl #(.DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .div_start    (div_start),
        .div_unsigned (div_unsigned),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .mt_hi        (mt_hi),
        .mt_lo        (mt_lo),
        .mt_data      (mt_data),
        .busy         (busy),
        .done         (done),
        .div_zero     (div_zero),
        .hi           (hi),
        .lo           (lo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference division in 64-bit arithmetic, so the most-negative / -1 case has no overflow.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic uns,
                                    output logic [31:0] q, output logic [31:0] r);
        longint a64, b64, q64, r64;
        if (uns) begin
            a64 = longint'({32'd0, a});
            b64 = longint'({32'd0, b});
        end else begin
            a64 = longint'($signed(a));
            b64 = longint'($signed(b));
        end
        q64 = a64 / b64;
        r64 = a64 % b64;
        q = q64[31:0];
        r = r64[31:0];
    endfunction

    // Cycle-level expectation: busy covers 33 cycles after the accepting edge, then the
    // result lands with a done pulse; MT writes and new requests only count while idle.
    int          left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_busy, m_done, m_dz;

    always @(posedge clk) begin
        if (reset) begin
            left = 0; m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dz = 0;
        end else begin
            m_done = 0;
            m_dz   = 0;
            if (left == 0) begin
                if (mt_hi) m_hi = mt_data;
                if (mt_lo) m_lo = mt_data;
                if (div_start) begin
                    if (rt_val == 32'd0) begin
                        m_done = 1;
                        m_dz   = 1;
                    end else begin
                        ref_div(rs_val, rt_val, div_unsigned, p_lo, p_hi);
                        left = 33;
                    end
                end
            end else begin
                left--;
                if (left == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1;
                end
            end
            m_busy = (left != 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     {31'd0, busy},     {31'd0, m_busy});
            chk("done",     {31'd0, done},     {31'd0, m_done});
            chk("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
            chk("hi",       hi, m_hi);
            chk("lo",       lo, m_lo);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic uns);
        div_start = 1'b1; div_unsigned = uns; rs_val = a; rt_val = b;
        step();
        div_start = 1'b0;
    endtask

    // Waits for done (bounded); returns number of cycles busy was seen high.
    task automatic wait_done(input string name, output int busy_cycles);
        int i;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        for (i = 0; i < 60 && done !== 1'b1; i++) begin
            step();
            if (busy === 1'b1) busy_cycles++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: got done=%b expected done=1 within 60 cycles", name, done);
        end
    endtask

    logic [31:0] q, r;
    int          bc;
    int          dones;

    initial begin
        reset = 1'b1; div_start = 0; div_unsigned = 0; rs_val = 0; rt_val = 0;
        mt_hi = 0; mt_lo = 0; mt_data = 0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        step();

        // Pin the reference model against hand-computed values.
        ref_div(32'd100, 32'd7, 1'b1, q, r);
        chk("model_q_100_7", q, 32'd14);
        chk("model_r_100_7", r, 32'd2);
        ref_div(32'h80000000, 32'hFFFFFFFF, 1'b0, q, r);
        chk("model_q_min_m1", q, 32'h80000000);
        chk("model_r_min_m1", r, 32'd0);
        ref_div(32'hFFFFFFF9, 32'd2, 1'b0, q, r);
        chk("model_q_m7_2", q, 32'hFFFFFFFD);
        chk("model_r_m7_2", r, 32'hFFFFFFFF);

        // 1. DIVU 100/7
        start_div(32'd100, 32'd7, 1'b1);
        wait_done("t1", bc);
        chk("t1_busy_cycles", bc, 32'd33);
        chk("t1_lo", lo, 32'd14);
        chk("t1_hi", hi, 32'd2);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done === 1'b1) dones++;
        end
        chk("t1_done_once", dones, 32'd0);

        // 2. Signed rules
        start_div(32'hFFFFFFF9, 32'd2, 1'b0);
        wait_done("t2a", bc);
        chk("t2a_lo", lo, 32'hFFFFFFFD);
        chk("t2a_hi", hi, 32'hFFFFFFFF);
        step();
        start_div(32'd7, 32'hFFFFFFFE, 1'b0);
        wait_done("t2b", bc);
        chk("t2b_lo", lo, 32'hFFFFFFFD);
        chk("t2b_hi", hi, 32'd1);
        step();

        // 3. Boundaries
        start_div(32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_done("t3a", bc);
        chk("t3a_lo", lo, 32'h80000000);
        chk("t3a_hi", hi, 32'd0);
        step();
        start_div(32'hFFFFFFFF, 32'd1, 1'b1);
        wait_done("t3b", bc);
        chk("t3b_lo", lo, 32'hFFFFFFFF);
        chk("t3b_hi", hi, 32'd0);
        step();

        // 4. Preload via MT, then divide by zero
        mt_hi = 1; mt_data = 32'hAA; step();
        mt_hi = 0; mt_lo = 1; mt_data = 32'hBB; step();
        mt_lo = 0;
        start_div(32'd1234, 32'd0, 1'b0);
        chk("t4_div_zero", {31'd0, div_zero}, 32'd1);
        chk("t4_done",     {31'd0, done},     32'd1);
        chk("t4_busy",     {31'd0, busy},     32'd0);
        step();
        chk("t4_div_zero_clr", {31'd0, div_zero}, 32'd0);
        chk("t4_done_clr",     {31'd0, done},     32'd0);
        chk("t4_hi", hi, 32'hAA);
        chk("t4_lo", lo, 32'hBB);

        // 5. Reset mid-divide, then a fresh divide
        start_div(32'd1000, 32'd3, 1'b1);
        repeat (10) step();
        chk("t5_busy_before_rst", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_hi", hi, 32'd0);
        chk("t5_rst_lo", lo, 32'd0);
        start_div(32'd9, 32'd4, 1'b1);
        wait_done("t5", bc);
        chk("t5_busy_cycles", bc, 32'd33);
        chk("t5_lo", lo, 32'd2);
        chk("t5_hi", hi, 32'd1);
        step();

        // 6. Requests while busy are dropped; MT works again when idle
        start_div(32'd50, 32'd6, 1'b1);
        repeat (5) step();
        div_start = 1; div_unsigned = 1; rs_val = 32'd999; rt_val = 32'd10;
        mt_hi = 1; mt_data = 32'h55;
        step();
        div_start = 0; mt_hi = 0;
        chk("t6_hi_not_written", hi, 32'd1);
        wait_done("t6", bc);
        chk("t6_lo", lo, 32'd8);
        chk("t6_hi", hi, 32'd2);
        step();
        chk("t6_no_restart", {31'd0, busy}, 32'd0);
        mt_hi = 1; mt_data = 32'h55;
        step();
        mt_hi = 0;
        chk("t6_mthi", hi, 32'h55);
        chk("t6_lo_kept", lo, 32'd8);

        // MT accepted alongside div_start, then overwritten by the result
        mt_hi = 1; mt_lo = 1; mt_data = 32'h77;
        start_div(32'd20, 32'd3, 1'b1);
        mt_hi = 0; mt_lo = 0;
        chk("t7_mt_same_cycle_hi", hi, 32'h77);
        chk("t7_mt_same_cycle_lo", lo, 32'h77);
        wait_done("t7", bc);
        chk("t7_lo", lo, 32'd6);
        chk("t7_hi", hi, 32'd2);
        step();
        step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
